// File: rtl/sdram_port_sched.sv
// sdram_port_sched
// Chooses which Wishbone port owns the SDRAM access interface. Rotating
// round-robin arbitration with an explicit grant/drain sequence. When
// SDRAM_SCHED_QUANTUM_EN is defined, a per-grant beat quantum asks a busy
// port to yield once other ports are waiting. Without the macro, a grant
// lasts until the owner drops its request, and yield_o is tied low.
//
// Ports:
//   sdram_clk, sdram_rst_n  clock, async active-low reset
//   req_i      per-port request level
//   idle_i     SDRAM controller idle
//   ack_i      one data beat accepted for the granted port
//   gnt_o      one-hot grant
//   gnt_enc_o  binary index of the granted port (held after release)
//   gnt_vld_o  grant active
//   yield_o    one-hot request to the owner to drop its request
//   switch_o   one-cycle pulse when a new grant is issued
//
// state   | meaning
// S_IDLE  | no owner; arbitrate when a request is pending and the controller is idle
// S_GRANT | owner active; count beats and raise yield when the quantum is used up
// S_DRAIN | owner released; hold the grant until the controller goes idle

module sdram_port_sched #(
  parameter int WB_PORTS = 3,
  parameter int QUANTUM  = 16,
  localparam int GW = $clog2(WB_PORTS)
) (
  input  logic                sdram_clk,
  input  logic                sdram_rst_n,
  input  logic [WB_PORTS-1:0] req_i,
  input  logic                idle_i,
  input  logic                ack_i,
  output logic [WB_PORTS-1:0] gnt_o,
  output logic [GW-1:0]       gnt_enc_o,
  output logic                gnt_vld_o,
  output logic [WB_PORTS-1:0] yield_o,
  output logic                switch_o
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [WB_PORTS-1:0] req_q;
  logic                idle_q;
  logic [GW-1:0]       last_ptr, last_nxt;
  logic [WB_PORTS-1:0] gnt_nxt;
  logic [GW-1:0]       enc_nxt;
  logic                vld_nxt, switch_nxt;

  logic                hi_found, lo_found;
  logic [GW-1:0]       hi_idx, lo_idx, win_idx;
  logic [WB_PORTS-1:0] win_onehot;
  logic                any_req, own_req, competitor;

`ifdef SDRAM_SCHED_QUANTUM_EN
  localparam int CW = $clog2(QUANTUM + 1);
  logic                ack_q;
  logic [CW-1:0]       beat_cnt, cnt_nxt;
  logic [WB_PORTS-1:0] yield_q, yield_nxt;
  assign yield_o = yield_q;
`else
  localparam int unused_quantum = QUANTUM;
  logic unused_ack;
  assign unused_ack = ack_i;
  assign yield_o    = '0;
`endif

  // Inputs are registered once; the FSM acts on the registered copies so
  // every decision is one cycle behind the request lines.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      req_q  <= '0;
      idle_q <= 1'b0;
`ifdef SDRAM_SCHED_QUANTUM_EN
      ack_q  <= 1'b0;
`endif
    end else begin
      req_q  <= req_i;
      idle_q <= idle_i;
`ifdef SDRAM_SCHED_QUANTUM_EN
      ack_q  <= ack_i;
`endif
    end
  end

  // First requester strictly after last_ptr: lowest index above last_ptr,
  // else the lowest index at or below it (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = WB_PORTS - 1; i >= 0; i--) begin
      if (req_q[i]) begin
        if (i > int'(last_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = GW'(i);
        end
      end
    end
  end

  assign win_idx    = hi_found ? hi_idx : lo_idx;
  assign win_onehot = WB_PORTS'(1) << win_idx;
  assign any_req    = hi_found | lo_found;
  assign own_req    = req_q[gnt_enc_o];
  assign competitor = |(req_q & ~gnt_o);

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_o;
    enc_nxt    = gnt_enc_o;
    vld_nxt    = gnt_vld_o;
    switch_nxt = 1'b0;
    last_nxt   = last_ptr;
`ifdef SDRAM_SCHED_QUANTUM_EN
    cnt_nxt    = beat_cnt;
    yield_nxt  = '0;
`endif
    case (state)
      S_IDLE: begin
        gnt_nxt = '0;
        vld_nxt = 1'b0;
        if (any_req && idle_q) begin
          gnt_nxt    = win_onehot;
          enc_nxt    = win_idx;
          last_nxt   = win_idx;
          vld_nxt    = 1'b1;
          switch_nxt = 1'b1;
          state_nxt  = S_GRANT;
`ifdef SDRAM_SCHED_QUANTUM_EN
          cnt_nxt    = '0;
`endif
        end
      end
      S_GRANT: begin
`ifdef SDRAM_SCHED_QUANTUM_EN
        if (ack_q && beat_cnt != CW'(QUANTUM)) cnt_nxt = beat_cnt + 1'b1;
`endif
        if (!own_req) begin
          state_nxt = S_DRAIN;
`ifdef SDRAM_SCHED_QUANTUM_EN
        end else if (yield_q != '0) begin
          // Once raised, yield stays until the owner lets go.
          yield_nxt = yield_q;
        end else if (cnt_nxt == CW'(QUANTUM) && competitor) begin
          yield_nxt = gnt_o;
`endif
        end
      end
      S_DRAIN: begin
        if (idle_q) begin
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        vld_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state     <= S_IDLE;
      gnt_o     <= '0;
      gnt_enc_o <= '0;
      gnt_vld_o <= 1'b0;
      switch_o  <= 1'b0;
      last_ptr  <= GW'(WB_PORTS - 1);
`ifdef SDRAM_SCHED_QUANTUM_EN
      beat_cnt  <= '0;
      yield_q   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      gnt_o     <= gnt_nxt;
      gnt_enc_o <= enc_nxt;
      gnt_vld_o <= vld_nxt;
      switch_o  <= switch_nxt;
      last_ptr  <= last_nxt;
`ifdef SDRAM_SCHED_QUANTUM_EN
      beat_cnt  <= cnt_nxt;
      yield_q   <= yield_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_port_sched.sv
module tb_sdram_port_sched;

  localparam int NP = 3;
  localparam int Q  = 4;
  localparam int GW = $clog2(NP);
`ifdef SDRAM_SCHED_QUANTUM_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] req;
  logic          idle;
  logic          ack;
  logic [NP-1:0] gnt;
  logic [GW-1:0] gnt_enc;
  logic          gnt_vld;
  logic [NP-1:0] yield_v;
  logic          sw;

  int errors = 0;
  int checks = 0;

  sdram_port_sched #(.WB_PORTS(NP), .QUANTUM(Q)) dut (
    .sdram_clk  (clk),
    .sdram_rst_n(rst_n),
    .req_i      (req),
    .idle_i     (idle),
    .ack_i      (ack),
    .gnt_o      (gnt),
    .gnt_enc_o  (gnt_enc),
    .gnt_vld_o  (gnt_vld),
    .yield_o    (yield_v),
    .switch_o   (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the bus, in which phase, and the request
  // lines as the scheduler last observed them.
  int            m_owner;   // -1 when nobody holds a grant
  int            m_phase;   // 0 free, 1 owned, 2 released/waiting for idle
  int            m_last;
  int            m_enc;
  int            m_cnt;
  bit            m_yield;
  bit            m_switch;
  logic [NP-1:0] m_rq;
  bit            m_iq;
  bit            m_aq;

  function automatic logic [NP-1:0] bit_of(input int p);
    logic [NP-1:0] one;
    one = 1;
    return one << p;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_phase = 0; m_last = NP - 1; m_enc = 0; m_cnt = 0;
    m_yield = 0; m_switch = 0; m_rq = '0; m_iq = 0; m_aq = 0;
  endtask

  task automatic model_edge();
    bit found;
    int p;
    m_switch = 0;
    if (m_phase == 0) begin
      if (m_rq != '0 && m_iq) begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          p = (m_last + k) % NP;
          if (!found && (m_rq & bit_of(p)) != '0) begin
            found = 1;
            m_owner = p;
          end
        end
        m_last = m_owner; m_enc = m_owner; m_cnt = 0; m_switch = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_aq && m_cnt < Q) m_cnt++;
      if ((m_rq & bit_of(m_owner)) == '0) begin
        m_phase = 2;
        m_yield = 0;
      end else if (QEN && !m_yield && m_cnt == Q && (m_rq & ~bit_of(m_owner)) != '0) begin
        m_yield = 1;
      end
    end else begin
      if (m_iq) begin
        m_phase = 0;
        m_owner = -1;
      end
    end
    m_rq = req; m_iq = idle; m_aq = ack;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NP-1:0] eg;
    eg = (m_owner >= 0) ? bit_of(m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_enc", 32'(gnt_enc), 32'(m_enc));
    chk("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    chk("yield", 32'(yield_v), 32'(m_yield ? eg : '0));
    chk("switch", 32'(sw), 32'(m_switch));
  endtask

  task automatic step(input logic [NP-1:0] r, input logic idl, input logic ak);
    req = r; idle = idl; ack = ak;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int x;
    bit got;
    bit seen_yield;
    logic [NP-1:0] r;

    rst_n = 1'b0; req = '0; idle = 1'b0; ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // first arbitration: port 0 not requesting, port 1 wins
    step(3'b110, 1'b1, 1'b0);
    chk("pre_grant_vld", 32'(gnt_vld), 32'd0);
    step(3'b110, 1'b1, 1'b0);
    chk("first_gnt", 32'(gnt), 32'b010);
    chk("first_enc", 32'(gnt_enc), 32'd1);
    chk("first_switch", 32'(sw), 32'd1);
    step(3'b110, 1'b1, 1'b0);
    chk("switch_one_cycle", 32'(sw), 32'd0);

    // quantum reached with port 2 waiting
    repeat (4) step(3'b110, 1'b1, 1'b1);
    step(3'b110, 1'b1, 1'b0);
    chk("quantum_yield", 32'(yield_v), QEN ? 32'b010 : 32'b000);
    repeat (2) step(3'b110, 1'b1, 1'b0);
    chk("yield_sticky", 32'(yield_v), QEN ? 32'b010 : 32'b000);
    repeat (5) step(3'b100, 1'b1, 1'b0);
    chk("handover_gnt", 32'(gnt), 32'b100);

    // lone requester never yields
    repeat (20) step(3'b100, 1'b1, 1'b1);
    step(3'b100, 1'b1, 1'b0);
    chk("lone_no_yield", 32'(yield_v), 32'd0);
    chk("lone_held", 32'(gnt), 32'b100);

    // everyone requesting, prompt release; drain held while controller busy
    x = 2;
    for (int n = 0; n < 4; n++) begin
      r = 3'b111 & ~bit_of(x);
      repeat (4) step(r, 1'b0, 1'b0);
      chk("drain_hold_vld", 32'(gnt_vld), 32'd1);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        step(3'b111, 1'b1, 1'b0);
        if (sw) got = 1;
      end
      chk("rotate_switch", 32'(got), 32'd1);
      x = (x + 1) % NP;
      chk("rotate_enc", 32'(gnt_enc), 32'(x));
    end

    // owner drops on the same cycle as the quantum-completing beat
    repeat (3) step(3'b111, 1'b1, 1'b1);
    seen_yield = 0;
    step(3'b110, 1'b1, 1'b1);
    if (yield_v != '0) seen_yield = 1;
    repeat (4) begin
      step(3'b110, 1'b1, 1'b0);
      if (yield_v != '0) seen_yield = 1;
    end
    chk("simul_no_yield", 32'(seen_yield), 32'd0);
    chk("simul_next_gnt", 32'(gnt), 32'b010);

    // asynchronous reset mid-grant
    req = 3'b111; idle = 1'b1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b0);
    chk("post_reset_gnt", 32'(gnt), 32'b001);

    // randomized traffic with reactive port agents
    r = 3'b111;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if ((r & bit_of(p)) != '0) begin
          if (gnt_vld && int'(gnt_enc) == p &&
              ((yield_v & bit_of(p)) != '0 || $urandom_range(0, 7) == 0))
            r = r & ~bit_of(p);
          else if ($urandom_range(0, 31) == 0)
            r = r & ~bit_of(p);
        end else if ($urandom_range(0, 3) == 0) begin
          r = r | bit_of(p);
        end
      end
      step(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
